// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder
//   Packs symbolic RV32I operations into 32-bit instruction words and streams
//   them into instruction memory through a small FIFO.
//
//   Ports
//     clk, rst_n            clock (rising edge), asynchronous active-low reset
//     start, start_addr     flush FIFO, reload write address, clear count/error
//     in_valid/in_ready     op request handshake
//     in_op                 op selector (NOP, LW, SW, ALU, shifts, branches, jumps, LUI, AUIPC)
//     in_rd/in_rs1/in_rs2   register fields, ignored where the format has none
//     in_imm                byte immediate; full value for LUI/AUIPC
//     imem_wen/imem_ready   memory write handshake
//     imem_addr/imem_wdata  word address and instruction word (stable while stalled)
//     wr_count              words written since reset/start, wraps
//     err_imm               sticky illegal-immediate flag
//     idle                  FIFO empty, nothing to write
module rv32i_inst_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_wen,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_imm,
  output logic              idle
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LVL_W-1:0]  PTR_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,  OP_LW    = 5'd1,  OP_SW    = 5'd2,  OP_ADD   = 5'd3,
    OP_ADDI  = 5'd4,  OP_SUB   = 5'd5,  OP_AND   = 5'd6,  OP_OR    = 5'd7,
    OP_XOR   = 5'd8,  OP_ANDI  = 5'd9,  OP_ORI   = 5'd10, OP_XORI  = 5'd11,
    OP_SLL   = 5'd12, OP_SRL   = 5'd13, OP_SRA   = 5'd14, OP_SLLI  = 5'd15,
    OP_SRLI  = 5'd16, OP_SRAI  = 5'd17, OP_SLT   = 5'd18, OP_SLTU  = 5'd19,
    OP_SLTI  = 5'd20, OP_SLTIU = 5'd21, OP_BEQ   = 5'd22, OP_BNE   = 5'd23,
    OP_BLT   = 5'd24, OP_BGE   = 5'd25, OP_BLTU  = 5'd26, OP_BGEU  = 5'd27,
    OP_JAL   = 5'd28, OP_JALR  = 5'd29, OP_LUI   = 5'd30, OP_AUIPC = 5'd31
  } op_e;

  typedef enum logic [2:0] {
    FMT_NOP, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // ---------------------------------------------------------------------------
  // Op decode: format, opcode, funct3, funct7
  // ---------------------------------------------------------------------------
  op_e        op;
  fmt_e       fmt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign op = op_e'(in_op);

  always_comb begin
    fmt = FMT_NOP;
    opc = OPC_OPIMM;
    f3  = 3'b000;
    f7  = 7'b0000000;
    unique case (op)
      OP_NOP:   fmt = FMT_NOP;
      OP_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;  f3 = 3'b010; end
      OP_SW:    begin fmt = FMT_S;  opc = OPC_STORE; f3 = 3'b010; end
      OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b000; end
      OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b000; f7 = F7_ALT; end
      OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b001; end
      OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b010; end
      OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b011; end
      OP_XOR:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b100; end
      OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b101; end
      OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b101; f7 = F7_ALT; end
      OP_OR:    begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b110; end
      OP_AND:   begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b111; end
      OP_ADDI:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b000; end
      OP_SLTI:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b010; end
      OP_SLTIU: begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b011; end
      OP_XORI:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b100; end
      OP_ORI:   begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b110; end
      OP_ANDI:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b111; end
      OP_SLLI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b001; end
      OP_SRLI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b101; end
      OP_SRAI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b101; f7 = F7_ALT; end
      OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b000; end
      OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b001; end
      OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b100; end
      OP_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b101; end
      OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b110; end
      OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b111; end
      OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL; end
      OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;  f3 = 3'b000; end
      OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI; end
      OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC; end
      default:  fmt = FMT_NOP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate range checks. A signed range of 2^k values is legal exactly when
  // every bit from k-1 upward matches (pure sign extension).
  // ---------------------------------------------------------------------------
  logic imm_i_ok, imm_sh_ok, imm_b_ok, imm_j_ok, imm_u_ok;

  assign imm_i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm_sh_ok = ~(|in_imm[31:5]);
  assign imm_b_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign imm_j_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign imm_u_ok  = ~(|in_imm[11:0]);

  // ---------------------------------------------------------------------------
  // Word packing
  // ---------------------------------------------------------------------------
  logic [31:0] word;
  logic        legal;

  always_comb begin
    word  = 32'h0000_0013;
    legal = 1'b1;
    unique case (fmt)
      FMT_NOP: begin
        word  = 32'h0000_0013;
        legal = 1'b1;
      end
      FMT_R: begin
        word  = {f7, in_rs2, in_rs1, f3, in_rd, opc};
        legal = 1'b1;
      end
      FMT_I: begin
        word  = {in_imm[11:0], in_rs1, f3, in_rd, opc};
        legal = imm_i_ok;
      end
      FMT_SH: begin
        word  = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
        legal = imm_sh_ok;
      end
      FMT_S: begin
        word  = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
        legal = imm_i_ok;
      end
      FMT_B: begin
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                 in_imm[4:1], in_imm[11], opc};
        legal = imm_b_ok;
      end
      FMT_U: begin
        word  = {in_imm[31:12], in_rd, opc};
        legal = imm_u_ok;
      end
      FMT_J: begin
        word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
        legal = imm_j_ok;
      end
      default: begin
        word  = 32'h0000_0013;
        legal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO and write port
  // ---------------------------------------------------------------------------
  logic [31:0]       mem_q [DEPTH];
  logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [LVL_W-1:0]  level;
  logic              empty, full;
  logic              accept, push, pop;

  assign level  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (level == LVL_FULL);

  // in_ready depends only on registered level, so a pop this cycle cannot
  // make room for a push in the same cycle.
  assign in_ready = ~full & ~start;
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = ~empty & imem_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (start) begin
      // A same-cycle memory handshake still happens on the bus, but the
      // restart values override its address/count update.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      addr_d   = start_addr;
      cnt_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        addr_d   = addr_q + ADDR_ONE;
        cnt_d    = cnt_q + CNT_ONE;
      end
      if (accept && !legal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= BASE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= word;
    end
  end

  assign imem_wen   = ~empty;
  assign imem_addr  = addr_q;
  assign imem_wdata = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign wr_count   = cnt_q;
  assign err_imm    = err_q;
  assign idle       = empty;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
module tb_rv32i_inst_encoder;

  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int AMOD  = 1 << AW;
  localparam int CMOD  = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          imem_wen;
  logic          imem_ready = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   wr_count;
  logic          err_imm;
  logic          idle;

  int n_checks = 0;
  int n_pass   = 0;

  rv32i_inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_wen(imem_wen), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .wr_count(wr_count), .err_imm(err_imm), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference encoder: field placement by arithmetic on the ISA tables.
  function automatic bit [31:0] enc(input int op, input int rd, input int rs1,
                                    input int rs2, input int imm, output bit ok);
    // fmt: 0 NOP, 1 R, 2 I, 3 shift-imm, 4 S, 5 B, 6 U, 7 J
    int fmt, opc, f3, f7;
    bit [31:0] u, r, a, b, w;
    u = imm; r = rd; a = rs1; b = rs2;
    fmt = 0; opc = 0; f3 = 0; f7 = 0;
    case (op)
      1:  begin fmt = 2; opc = 'h03; f3 = 2; end
      2:  begin fmt = 4; opc = 'h23; f3 = 2; end
      3:  begin fmt = 1; opc = 'h33; f3 = 0; end
      4:  begin fmt = 2; opc = 'h13; f3 = 0; end
      5:  begin fmt = 1; opc = 'h33; f3 = 0; f7 = 'h20; end
      6:  begin fmt = 1; opc = 'h33; f3 = 7; end
      7:  begin fmt = 1; opc = 'h33; f3 = 6; end
      8:  begin fmt = 1; opc = 'h33; f3 = 4; end
      9:  begin fmt = 2; opc = 'h13; f3 = 7; end
      10: begin fmt = 2; opc = 'h13; f3 = 6; end
      11: begin fmt = 2; opc = 'h13; f3 = 4; end
      12: begin fmt = 1; opc = 'h33; f3 = 1; end
      13: begin fmt = 1; opc = 'h33; f3 = 5; end
      14: begin fmt = 1; opc = 'h33; f3 = 5; f7 = 'h20; end
      15: begin fmt = 3; opc = 'h13; f3 = 1; end
      16: begin fmt = 3; opc = 'h13; f3 = 5; end
      17: begin fmt = 3; opc = 'h13; f3 = 5; f7 = 'h20; end
      18: begin fmt = 1; opc = 'h33; f3 = 2; end
      19: begin fmt = 1; opc = 'h33; f3 = 3; end
      20: begin fmt = 2; opc = 'h13; f3 = 2; end
      21: begin fmt = 2; opc = 'h13; f3 = 3; end
      22, 23, 24, 25, 26, 27: begin
        fmt = 5; opc = 'h63;
        f3 = (op == 22) ? 0 : (op == 23) ? 1 : op - 20;
      end
      28: begin fmt = 7; opc = 'h6F; end
      29: begin fmt = 2; opc = 'h67; f3 = 0; end
      30: begin fmt = 6; opc = 'h37; end
      31: begin fmt = 6; opc = 'h17; end
      default: fmt = 0;
    endcase
    ok = 1'b1;
    w  = 32'h13;
    case (fmt)
      1: w = (f7 << 25) | (b << 20) | (a << 15) | (f3 << 12) | (r << 7) | opc;
      2: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = ((u & 'hFFF) << 20) | (a << 15) | (f3 << 12) | (r << 7) | opc;
      end
      3: begin
        ok = (imm >= 0) && (imm <= 31);
        w  = (f7 << 25) | ((u & 31) << 20) | (a << 15) | (f3 << 12) | (r << 7) | opc;
      end
      4: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = (((u >> 5) & 127) << 25) | (b << 20) | (a << 15) | (f3 << 12)
           | ((u & 31) << 7) | opc;
      end
      5: begin
        ok = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (b << 20) | (a << 15)
           | (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | opc;
      end
      6: begin
        ok = (u & 'hFFF) == 0;
        w  = (u & 32'hFFFF_F000) | (r << 7) | opc;
      end
      7: begin
        ok = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
           | (((u >> 12) & 255) << 12) | (r << 7) | opc;
      end
      default: w = 32'h13;
    endcase
    return w;
  endfunction

  // Behavioural model: queue of pending words plus address/count/error.
  bit [31:0] mq[$];
  int        m_addr = 0;
  int        m_cnt  = 0;
  bit        m_err  = 1'b0;

  // Inputs change only at posedge+1, so at the negedge they hold the values
  // the next rising edge will sample.
  always @(negedge clk) begin : cmp
    bit [31:0] w;
    bit        ok, wen, rdy;
    if (!rst_n) begin
      mq.delete();
      m_addr = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      wen = (mq.size() != 0);
      rdy = (mq.size() < DEPTH) && !start;
      chk("wen", imem_wen, wen);
      chk("idle", idle, !wen);
      chk("in_ready", in_ready, rdy);
      chk("addr", imem_addr, m_addr);
      chk("count", wr_count, m_cnt);
      chk("err_imm", err_imm, m_err);
      if (wen) chk("wdata", imem_wdata, mq[0]);
      if (start) begin
        mq.delete();
        m_addr = start_addr; m_cnt = 0; m_err = 1'b0;
      end else begin
        if (wen && imem_ready) begin
          void'(mq.pop_front());
          m_addr = (m_addr + 1) % AMOD;
          m_cnt  = (m_cnt + 1) % CMOD;
        end
        if (in_valid && rdy) begin
          w = enc(in_op, in_rd, in_rs1, in_rs2, in_imm, ok);
          if (ok) mq.push_back(w);
          else m_err = 1'b1;
        end
      end
    end
  end

  // Drive one op; returns at posedge+1 after the accepting edge.
  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
    bit acc = 1'b0;
    in_op = op[4:0]; in_rd = rd[4:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0];
    in_imm = imm; in_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: op %0d never accepted", op);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
      done = idle;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL idle_timeout: FIFO never drained");
    end
  endtask

  task automatic pulse_start(input int a);
    start = 1'b1; start_addr = a[AW-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic int pick_imm();
    int bnd[16] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                    -4098, 1048574, -1048576, 1048576, 31, 32, 0, -1};
    case ($urandom % 8)
      0: return int'($urandom_range(0, 31)) - 16;
      1: return bnd[$urandom % 16];
      2: return int'($urandom);
      3: return int'($urandom & 32'hFFFF_F000);
      4: return int'($urandom_range(0, 63));
      5: return int'($urandom_range(0, 10000)) - 5000;
      6: return int'($urandom_range(0, 4194304)) - 2097152;
      default: return 2 * (int'($urandom_range(0, 200)) - 100);
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    bit [31:0] w0;
    // Model pins
    chk("pin_addi", enc(4, 1, 0, 0, 5, ok), 32'h0050_0093);
    chk("pin_sw",   enc(2, 7, 1, 2, -4, ok), 32'hFE20_AE23);
    chk("pin_jal",  enc(28, 1, 5, 0, 8, ok), 32'h0080_00EF);
    chk("pin_nop",  enc(0, 9, 9, 9, 77, ok), 32'h0000_0013);
    chk("pin_srai", enc(17, 2, 3, 0, 4, ok), 32'h4041_D113);
    void'(enc(4, 0, 0, 0, 2048, ok));     chk("pin_i_over", ok, 0);
    void'(enc(22, 0, 0, 0, -4096, ok));   chk("pin_b_min", ok, 1);
    void'(enc(28, 0, 0, 0, 1048576, ok)); chk("pin_j_over", ok, 0);

    // Reset state, no clock edge yet
    #1;
    chk("rst_wen", imem_wen, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_err", err_imm, 0);
    chk("rst_idle", idle, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // First op: visible the cycle after acceptance, at the base address
    send(4, 1, 0, 0, 5);
    chk("addi_wen", imem_wen, 1);
    chk("addi_addr", imem_addr, 0);
    chk("addi_wdata", imem_wdata, 32'h0050_0093);
    @(posedge clk); #1;
    chk("addi_count", wr_count, 1);
    send(2, 7, 1, 2, -4);   chk("sw_wdata", imem_wdata, 32'hFE20_AE23);   wait_idle();
    send(28, 1, 5, 0, 8);   chk("jal_wdata", imem_wdata, 32'h0080_00EF);  wait_idle();
    send(0, 3, 4, 5, 99);   chk("nop_wdata", imem_wdata, 32'h0000_0013);  wait_idle();
    chk("seq_addr", imem_addr, 4);

    // Illegal branch offset: consumed, flagged, no write
    send(22, 0, 1, 2, 3);
    chk("beq_err", err_imm, 1);
    chk("beq_idle", idle, 1);
    send(3, 3, 1, 2, 0);
    chk("add_wdata", imem_wdata, 32'h0020_81B3);
    chk("add_addr", imem_addr, 4);
    wait_idle();
    pulse_start(0);
    chk("start_err", err_imm, 0);
    chk("start_count", wr_count, 0);

    // Back-pressure: FIFO fills, head held stable
    imem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4, i, 0, 0, i);
    chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_wdata", imem_wdata, 32'h0010_0093);
      chk("stall_addr", imem_addr, 0);
      @(posedge clk); #1;
    end
    fork
      send(4, 5, 0, 0, 5);
      begin repeat (3) @(posedge clk); #1 imem_ready = 1'b1; end
    join
    wait_idle();
    chk("bp_count", wr_count, 5);
    chk("bp_addr", imem_addr, 5);

    // Address wrap at 2^ADDR_W
    pulse_start(15);
    chk("wrap_start_addr", imem_addr, 15);
    send(6, 1, 2, 3, 0);
    chk("wrap_first_addr", imem_addr, 15);
    send(7, 4, 5, 6, 0);
    chk("wrap_second_addr", imem_addr, 0);
    wait_idle();
    chk("wrap_count", wr_count, 2);

    // Reset while a write is stalled
    imem_ready = 1'b0;
    send(30, 1, 0, 0, 32'h1234_5000);
    chk("pre_rst_wen", imem_wen, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wen", imem_wen, 0);
    chk("async_rst_addr", imem_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    imem_ready = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom % 4) != 0;
      in_op      = 5'($urandom);
      in_rd      = 5'($urandom);
      in_rs1     = 5'($urandom);
      in_rs2     = 5'($urandom);
      in_imm     = pick_imm();
      imem_ready = (c % 200 < 40) ? (($urandom % 6) == 0) : (($urandom % 4) != 0);
      start      = ($urandom % 150) == 0;
      start_addr = AW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0; imem_ready = 1'b1;
    wait_idle();
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
